// File: rtl/aes_round_controller.sv
// aes_round_controller: iterative AES-128 sequencer; owns state/key registers, round counter and rcon,
// and drives an external combinational single-round datapath for rounds 1..10.
module aes_round_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] rnd_state_out,
  output logic [127:0] rnd_key_out,
  output logic [7:0]   rnd_rcon,
  output logic         rnd_last,
  input  logic [127:0] rnd_state_in,
  input  logic [127:0] rnd_key_in,
  output logic         busy,
  output logic [3:0]   round
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, next;
  logic [127:0] state_reg, key_reg;
  logic [3:0] rcnt;
  logic legal;
  assign legal = rcnt >= 4'd1 && rcnt <= 4'd10;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rcnt      <= '0;
    end else begin
      state <= next;
      if (state == IDLE && in_valid) begin
        state_reg <= in_data ^ in_key;
        key_reg   <= in_key;
        rcnt      <= 4'd1;
      end else if (state == ROUND && legal) begin
        state_reg <= rnd_state_in;
        key_reg   <= rnd_key_in;
        if (rcnt != 4'd10) rcnt <= rcnt + 4'd1;
      end
    end
  end
  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        next     = in_valid ? ROUND : IDLE;
      end
      ROUND: begin
        busy = 1'b1;
        next = !legal ? IDLE : rcnt == 4'd10 ? DONE : ROUND;
      end
      DONE: begin
        out_valid = 1'b1;
        next      = out_ready ? IDLE : DONE;
      end
      default: next = IDLE;
    endcase
  end
  // rcon doubles in GF(2^8) for rounds 1..8, then wraps through the reduction polynomial
  assign rnd_rcon      = !(busy && legal) ? 8'h00 :
                         rcnt == 4'd9     ? 8'h1b :
                         rcnt == 4'd10    ? 8'h36 : 8'h01 << (rcnt - 4'd1);
  assign rnd_last      = busy && rcnt == 4'd10;
  assign round         = busy ? rcnt : 4'd0;
  assign out_data      = state_reg;
  assign rnd_state_out = state_reg;
  assign rnd_key_out   = key_reg;
endmodule
